// File: rtl/ncsp_fcw_ramp.sv
// ncsp_fcw_ramp
//   Frequency-control-word sweep generator feeding the MASH top level.
//   Produces an integer byte plus a 24-bit fraction (msb/isb/lsb bytes)
//   and sweeps it as a single up-ramp, a repeating sawtooth or a repeating
//   triangle. Runs on the modulator clock and its asynchronous FF reset.
//
// Ports
//   i_clk, i_ff_rst   modulator clock, asynchronous active-high reset
//   i_start           start pulse, honoured only while idle
//   i_stop            abort; returns to idle and freezes the output word
//   i_mode            00 single, 01 sawtooth, 10 triangle, 11 = 00
//   i_start_word      {int, frac} start value
//   i_step            unsigned fractional increment per tick
//   i_nsteps          steps per ramp leg
//   i_hold            ticks spent at each ramp end
//   i_div             one tick every i_div+1 clocks
//   o_int/o_msb/o_isb/o_lsb   accumulator bytes, straight from the register
//   o_busy            not idle
//   o_dir             1 while ramping down or holding at the bottom
//   o_sweep_done      one-clock pulse at the end of every sweep period
module ncsp_fcw_ramp #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 24,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_ff_rst,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [1:0]              i_mode,
  input  logic [INT_W+FRAC_W-1:0] i_start_word,
  input  logic [FRAC_W-1:0]       i_step,
  input  logic [CNT_W-1:0]        i_nsteps,
  input  logic [CNT_W-1:0]        i_hold,
  input  logic [DIV_W-1:0]        i_div,
  output logic [INT_W-1:0]        o_int,
  output logic [7:0]              o_msb,
  output logic [7:0]              o_isb,
  output logic [7:0]              o_lsb,
  output logic                    o_busy,
  output logic                    o_dir,
  output logic                    o_sweep_done
);

  localparam int ACC_W = INT_W + FRAC_W;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SAW    = 2'b01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP       = 3'd1,
    HOLD_TOP = 3'd2,
    DOWN     = 3'd3,
    HOLD_BOT = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;       // steps in a ramp leg, ticks in a hold
  logic [DIV_W-1:0]   div_cnt_reg, div_cnt_next;
  logic               done_reg, done_next;

  // Configuration captured at start; later input changes are ignored.
  logic [1:0]         mode_reg, mode_next;
  logic [ACC_W-1:0]   start_word_reg, start_word_next;
  logic [FRAC_W-1:0]  step_reg, step_next;
  logic [CNT_W-1:0]   nsteps_reg, nsteps_next;
  logic [CNT_W-1:0]   hold_reg, hold_next;
  logic [DIV_W-1:0]   div_reg, div_next;

  logic               tick;
  logic [CNT_W-1:0]   leg_len;
  logic               leg_last;
  logic [ACC_W-1:0]   step_ext;

  always_ff @(posedge i_clk or posedge i_ff_rst) begin
    if (i_ff_rst) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      div_cnt_reg    <= '0;
      done_reg       <= 1'b0;
      mode_reg       <= '0;
      start_word_reg <= '0;
      step_reg       <= '0;
      nsteps_reg     <= '0;
      hold_reg       <= '0;
      div_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      div_cnt_reg    <= div_cnt_next;
      done_reg       <= done_next;
      mode_reg       <= mode_next;
      start_word_reg <= start_word_next;
      step_reg       <= step_next;
      nsteps_reg     <= nsteps_next;
      hold_reg       <= hold_next;
      div_reg        <= div_next;
    end
  end

  assign tick     = (div_cnt_reg == div_reg);
  assign step_ext = {{INT_W{1'b0}}, step_reg};
  // Ramp legs count steps, holds count ticks; a zero length ends after one clock.
  assign leg_len  = ((state_reg == UP) || (state_reg == DOWN)) ? nsteps_reg : hold_reg;
  assign leg_last = (leg_len == '0) || (tick && ((cnt_reg + CNT_W'(1)) == leg_len));

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    div_cnt_next    = div_cnt_reg;
    done_next       = 1'b0;
    mode_next       = mode_reg;
    start_word_next = start_word_reg;
    step_next       = step_reg;
    nsteps_next     = nsteps_reg;
    hold_next       = hold_reg;
    div_next        = div_reg;

    if (state_reg == IDLE) begin
      if (i_start && !i_stop) begin
        mode_next       = (i_mode == 2'b11) ? MODE_SINGLE : i_mode;
        start_word_next = i_start_word;
        step_next       = i_step;
        nsteps_next     = i_nsteps;
        hold_next       = i_hold;
        div_next        = i_div;
        acc_next        = i_start_word;
        state_next      = UP;
      end
    end else if (i_stop) begin
      state_next = IDLE;
    end else begin
      if (tick) begin
        div_cnt_next = '0;
        cnt_next     = cnt_reg + CNT_W'(1);
      end else begin
        div_cnt_next = div_cnt_reg + DIV_W'(1);
      end

      case (state_reg)
        UP: begin
          if (tick && (leg_len != '0)) acc_next = acc_reg + step_ext;
          if (leg_last) begin
            if (mode_reg == MODE_SINGLE) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = HOLD_TOP;
            end
          end
        end
        HOLD_TOP: begin
          if (leg_last) begin
            if (mode_reg == MODE_SAW) begin
              acc_next   = start_word_reg;
              done_next  = 1'b1;
              state_next = UP;
            end else begin
              state_next = DOWN;
            end
          end
        end
        DOWN: begin
          if (tick && (leg_len != '0)) acc_next = acc_reg - step_ext;
          if (leg_last) state_next = HOLD_BOT;
        end
        HOLD_BOT: begin
          // No reload: the triangle closes on the start value unless it wrapped.
          if (leg_last) begin
            done_next  = 1'b1;
            state_next = UP;
          end
        end
        default: state_next = IDLE;
      endcase
    end

    // Every state entry restarts both the leg counter and the tick divider.
    if (state_next != state_reg) begin
      cnt_next     = '0;
      div_cnt_next = '0;
    end
  end

  assign o_int        = acc_reg[ACC_W-1 -: INT_W];
  assign o_msb        = acc_reg[FRAC_W-1 -: 8];
  assign o_isb        = acc_reg[FRAC_W-9 -: 8];
  assign o_lsb        = acc_reg[FRAC_W-17 -: 8];
  assign o_busy       = (state_reg != IDLE);
  assign o_dir        = (state_reg == DOWN) || (state_reg == HOLD_BOT);
  assign o_sweep_done = done_reg;

endmodule

// File: tb/tb_ncsp_fcw_ramp.sv
// tb_ncsp_fcw_ramp
//   Directed, table-driven bench for ncsp_fcw_ramp. Each row gives the
//   start/stop inputs for one clock and the expected outputs after that edge.
module tb_ncsp_fcw_ramp;

  logic        i_clk = 1'b0;
  logic        i_ff_rst;
  logic        i_start;
  logic        i_stop;
  logic [1:0]  i_mode;
  logic [31:0] i_start_word;
  logic [23:0] i_step;
  logic [15:0] i_nsteps;
  logic [15:0] i_hold;
  logic [7:0]  i_div;
  logic [7:0]  o_int, o_msb, o_isb, o_lsb;
  logic        o_busy, o_dir, o_sweep_done;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  ncsp_fcw_ramp dut (
    .i_clk(i_clk), .i_ff_rst(i_ff_rst), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_start_word(i_start_word), .i_step(i_step),
    .i_nsteps(i_nsteps), .i_hold(i_hold), .i_div(i_div),
    .o_int(o_int), .o_msb(o_msb), .o_isb(o_isb), .o_lsb(o_lsb),
    .o_busy(o_busy), .o_dir(o_dir), .o_sweep_done(o_sweep_done)
  );

  typedef struct {
    int          cfg;
    bit          start;
    bit          stop;
    logic [31:0] word;
    bit          busy;
    bit          dir;
    bit          done;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(int c, bit s, bit p, logic [31:0] w, bit b, bit d, bit dn);
    row_t r;
    r.cfg = c; r.start = s; r.stop = p; r.word = w; r.busy = b; r.dir = d; r.done = dn;
    return r;
  endfunction

  function automatic void add(int c, bit s, bit p, logic [31:0] w, bit b, bit d, bit dn);
    rows.push_back(mk(c, s, p, w, b, d, dn));
  endfunction

  task automatic drive_cfg(input int c);
    case (c)
      0: begin i_mode = 2'b00; i_start_word = 32'h1000_0000; i_step = 24'h000100; i_nsteps = 16'd4; i_hold = 16'd0; i_div = 8'd0; end
      1: begin i_mode = 2'b00; i_start_word = 32'hFFFF_FF00; i_step = 24'h000200; i_nsteps = 16'd1; i_hold = 16'd0; i_div = 8'd3; end
      2: begin i_mode = 2'b10; i_start_word = 32'h2000_0000; i_step = 24'h000010; i_nsteps = 16'd2; i_hold = 16'd1; i_div = 8'd0; end
      3: begin i_mode = 2'b01; i_start_word = 32'h3000_0000; i_step = 24'h000001; i_nsteps = 16'd3; i_hold = 16'd0; i_div = 8'd0; end
      default: begin i_mode = 2'b11; i_start_word = 32'h4000_0000; i_step = 24'h000005; i_nsteps = 16'd0; i_hold = 16'd0; i_div = 8'd0; end
    endcase
  endtask

  // Configuration inputs are scrambled on non-start rows: the design must
  // only use what it latched at start.
  task automatic drive_garbage();
    i_mode       = 2'($urandom);
    i_start_word = $urandom;
    i_step       = 24'($urandom);
    i_nsteps     = 16'($urandom);
    i_hold       = 16'($urandom);
    i_div        = 8'($urandom);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] w, input bit b, input bit d, input bit dn);
    chk({tag, " word"}, {o_int, o_msb, o_isb, o_lsb}, w);
    chk({tag, " busy"}, 32'(o_busy), 32'(b));
    chk({tag, " dir"},  32'(o_dir),  32'(d));
    chk({tag, " done"}, 32'(o_sweep_done), 32'(dn));
  endtask

  // Called at a negative edge; leaves the bench at the next negative edge.
  task automatic apply(input row_t r, input string tag);
    if (r.start) drive_cfg(r.cfg); else drive_garbage();
    i_start = r.start;
    i_stop  = r.stop;
    @(posedge i_clk);
    #1;
    $display("%s cfg=%0d start=%0b stop=%0b -> word=%h busy=%0b dir=%0b done=%0b",
             tag, r.cfg, r.start, r.stop, {o_int, o_msb, o_isb, o_lsb}, o_busy, o_dir, o_sweep_done);
    check_outs(tag, r.word, r.busy, r.dir, r.done);
    @(negedge i_clk);
  endtask

  initial begin
    // Single up-ramp, div=0
    add(0, 1, 0, 32'h1000_0000, 1, 0, 0);
    add(0, 0, 0, 32'h1000_0100, 1, 0, 0);
    add(0, 0, 0, 32'h1000_0200, 1, 0, 0);
    add(0, 0, 0, 32'h1000_0300, 1, 0, 0);
    add(0, 0, 0, 32'h1000_0400, 0, 0, 1);
    add(0, 0, 0, 32'h1000_0400, 0, 0, 0);
    // Divider of 3 and 32-bit wrap
    add(1, 1, 0, 32'hFFFF_FF00, 1, 0, 0);
    add(1, 0, 0, 32'hFFFF_FF00, 1, 0, 0);
    add(1, 0, 0, 32'hFFFF_FF00, 1, 0, 0);
    add(1, 0, 0, 32'hFFFF_FF00, 1, 0, 0);
    add(1, 0, 0, 32'h0000_0100, 0, 0, 1);
    // Triangle with hold=1, then stop during the second UP leg
    add(2, 1, 0, 32'h2000_0000, 1, 0, 0);
    add(2, 0, 0, 32'h2000_0010, 1, 0, 0);
    add(2, 0, 0, 32'h2000_0020, 1, 0, 0);
    add(2, 0, 0, 32'h2000_0020, 1, 1, 0);
    add(2, 0, 0, 32'h2000_0010, 1, 1, 0);
    add(2, 0, 0, 32'h2000_0000, 1, 1, 0);
    add(2, 0, 0, 32'h2000_0000, 1, 0, 1);
    add(2, 0, 0, 32'h2000_0010, 1, 0, 0);
    add(2, 0, 1, 32'h2000_0010, 0, 0, 0);
    // Sawtooth, three periods, reload coincides with done
    add(3, 1, 0, 32'h3000_0000, 1, 0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 3; k++) add(3, 0, 0, 32'h3000_0000 + 32'(k), 1, 0, 0);
      add(3, 0, 0, 32'h3000_0000, 1, 0, 1);
    end
    add(3, 0, 1, 32'h3000_0000, 0, 0, 0);
    // Start while busy ignored, stop mid-UP, start+stop in IDLE
    add(0, 1, 0, 32'h1000_0000, 1, 0, 0);
    add(0, 0, 0, 32'h1000_0100, 1, 0, 0);
    add(0, 1, 0, 32'h1000_0200, 1, 0, 0);
    add(0, 0, 1, 32'h1000_0200, 0, 0, 0);
    add(0, 0, 0, 32'h1000_0200, 0, 0, 0);
    add(0, 1, 1, 32'h1000_0200, 0, 0, 0);
    add(0, 0, 0, 32'h1000_0200, 0, 0, 0);
    // Mode 11 behaves as single; nsteps=0 ends after one clock with no step
    add(4, 1, 0, 32'h4000_0000, 1, 0, 0);
    add(4, 0, 0, 32'h4000_0000, 0, 0, 1);
    add(4, 0, 0, 32'h4000_0000, 0, 0, 0);

    i_ff_rst = 1'b1;
    i_start  = 1'b0;
    i_stop   = 1'b0;
    drive_cfg(0);
    #1;
    check_outs("reset", 32'h0, 0, 0, 0);
    repeat (2) @(negedge i_clk);
    i_ff_rst = 1'b0;

    for (int i = 0; i < rows.size(); i++)
      apply(rows[i], $sformatf("row%0d", i));

    // Reset during the DOWN leg of a triangle
    apply(mk(2, 1, 0, 32'h2000_0000, 1, 0, 0), "rst_a");
    apply(mk(2, 0, 0, 32'h2000_0010, 1, 0, 0), "rst_b");
    apply(mk(2, 0, 0, 32'h2000_0020, 1, 0, 0), "rst_c");
    apply(mk(2, 0, 0, 32'h2000_0020, 1, 1, 0), "rst_d");
    apply(mk(2, 0, 0, 32'h2000_0010, 1, 1, 0), "rst_e");
    i_ff_rst = 1'b1;
    #1;
    $display("rst_now word=%h busy=%0b dir=%0b", {o_int, o_msb, o_isb, o_lsb}, o_busy, o_dir);
    check_outs("rst_now", 32'h0, 0, 0, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_ff_rst = 1'b0;
    apply(mk(0, 0, 0, 32'h0, 0, 0, 0), "post_idle");
    apply(mk(0, 1, 0, 32'h1000_0000, 1, 0, 0), "post0");
    apply(mk(0, 0, 0, 32'h1000_0100, 1, 0, 0), "post1");
    apply(mk(0, 0, 0, 32'h1000_0200, 1, 0, 0), "post2");
    apply(mk(0, 0, 0, 32'h1000_0300, 1, 0, 0), "post3");
    apply(mk(0, 0, 0, 32'h1000_0400, 0, 0, 1), "post4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
